av_control_hub: RTL and testbench
=================================

// Module: av_control_hub
// PURPOSE
//  Frame-synchronous control hub between the audio analysis path and the pixel filter chain.
//  - Debounces NUM_FILTERS push-keys into per-stage filter enables.
//  - Clamps and frame-latches the BPM estimate.
//  - Stretches beat pulses into a frame-counted beat-active flag.
//  All outputs change only at frame start, so no stage ever sees a mid-frame parameter change.
// PARAMETERS
//  NUM_FILTERS   4        number of filter stages / keys controlled
//  BPM_W         8        width of BPM input and output
//  MIN_BPM       40       lower clamp for nonzero BPM
//  MAX_BPM       200      upper clamp for BPM
//  DEBOUNCE_CYC  250000   stable cycles for a key to count (10 ms @ 25 MHz)
//  HOLD_FRAMES   3        frames beat_active stays high after a beat edge
// PORTS
//  clk            in   1            pixel clock
//  reset          in   1            asynchronous, active-high
//  key_n          in   NUM_FILTERS  raw active-low keys, asynchronous
//  bpm_in         in   BPM_W        BPM estimate, valid when bpm_valid
//  bpm_valid      in   1            one-cycle strobe, already in clk domain
//  beat_in        in   1            beat level from audio domain, asynchronous
//  frame_start    in   1            one-cycle pulse at first pixel of a frame
//  filter_enable  out  NUM_FILTERS  committed per-stage enables
//  bpm_frame      out  BPM_W        committed clamped BPM
//  beat_active    out  1            high while beat hold count > 0
//  frame_count    out  16           frames since reset, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset values: filter_enable=0, bpm_frame=0, beat_active=0, frame_count=0.
//    All internal pending registers and counters also clear.
//    Reset mid-frame takes effect immediately, with no wait for frame_start.
//  - Keys: 2-FF synchroniser, then a debounce counter per key.
//    The debounced level updates after DEBOUNCE_CYC consecutive equal samples.
//    The counter restarts on any change.
//  - Key press: a debounced 1->0 transition of key_n toggles pend_en[i].
//    Release does nothing.
//  - BPM: on bpm_valid, pend_bpm is set as follows:
//      bpm_in == 0       -> 0 (no lock)
//      bpm_in < MIN_BPM  -> MIN_BPM
//      bpm_in > MAX_BPM  -> MAX_BPM
//      otherwise         -> bpm_in
//    Compares are unsigned at BPM_W.
//  - Commit: on frame_start, filter_enable<=pend_en, bpm_frame<=pend_bpm and frame_count++.
//    Latency is one cycle after the frame_start edge.
//    If bpm_valid and frame_start coincide, the new clamped value is committed in the same cycle (bypass).
//    If a key toggle and frame_start coincide, the toggled value is committed.
//  - Beat: beat_in passes through a 2-FF synchroniser; the rising edge is detected on the synced level.
//    A rising edge loads hold_cnt with HOLD_FRAMES.
//    A frame_start with hold_cnt > 0 decrements hold_cnt. Decrement saturates at 0.
//    Beat edge and frame_start in the same cycle: reload wins, with no decrement.
//    beat_active = registered (hold_cnt != 0). It updates immediately on the edge, not frame-gated.
//  - HOLD_FRAMES=0: beat_active never asserts.
//  - Two frame_starts with no intervening bpm_valid: bpm_frame stays unchanged.
// CONFIGURATION
//  - AV_HUB_KEY_MOMENTARY_EN defined:
//    pend_en[i] = debounced ~key_n[i], i.e. enabled while held (legacy key behaviour).
//    Still committed only at frame_start.
//  - Undefined (default): toggle-on-press as described above.
// STRUCTURE
//  - Package av_hub_pkg:
//    - typedef logic [7:0] bpm_t;
//    - localparam FRAME_CNT_W = 16;
//    - function clamp_bpm(bpm_t v, bpm_t lo, bpm_t hi).
//  - Sub-module key_debounce #(DEBOUNCE_CYC):
//    - ports: clk, reset, key_raw, key_level, press_pulse.
//    - instantiated NUM_FILTERS times in a generate loop.
//  - The beat synchroniser, hold counter and commit registers are inline in av_control_hub.
// TESTING (bench uses DEBOUNCE_CYC=4, HOLD_FRAMES=3)
//  1. Press key_n[1] for 6 cycles, then frame_start.
//     -> filter_enable==4'b0010 one cycle later.
//     Press again and send frame_start -> 4'b0000.
//  2. Bounce key_n[0] 0/1 every 2 cycles for 20 cycles, then release.
//     -> no toggle and filter_enable unchanged after frame_start.
//  3. bpm_valid with bpm_in=25, frame_start -> bpm_frame==40.
//     bpm_in=230 -> 200. bpm_in=0 -> 0. bpm_in=120 -> 120.
//  4. bpm_valid(90) coincident with frame_start -> bpm_frame==90 next cycle.
//  5. Beat rising edge, then 3 frame_starts -> beat_active high until the third frame_start, low after.
//     A beat edge coincident with the 2nd frame_start reloads the hold, giving 3 more frames.
//  6. Assert reset mid-frame with filter_enable=4'b1111 and bpm_frame=120.
//     -> all outputs 0 asynchronously. frame_count 0xFFFF + frame_start -> 0.

Source files
------------

// File: rtl/av_hub_pkg.sv
// Shared types and helpers for the audio/video control hub.
package av_hub_pkg;

   typedef logic [7:0] bpm_t;

   localparam int FRAME_CNT_W = 16;

   // Zero means "no lock" and passes through; anything else is held inside [lo, hi].
   function automatic bpm_t clamp_bpm(input bpm_t v, input bpm_t lo, input bpm_t hi);
      bpm_t r;
      if (v == 8'd0) begin
         r = 8'd0;
      end else if (v < lo) begin
         r = lo;
      end else if (v > hi) begin
         r = hi;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises one raw active-low key and debounces it; reports the debounced
// level and a one-cycle pulse on each debounced press (1->0).
module key_debounce #(
   parameter int DEBOUNCE_CYC = 250000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic key_level,
   output logic press_pulse
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [1:0]       sync_r;
   logic [CNT_W-1:0] cnt_r;
   logic             settle_s;

   // Synced sample has disagreed with the level for DEBOUNCE_CYC samples in a row.
   assign settle_s = (sync_r[1] != key_level) && (cnt_r == CNT_LAST);

   // Synchroniser, run-length counter and debounced level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r      <= 2'b11;
         cnt_r       <= '0;
         key_level   <= 1'b1;
         press_pulse <= 1'b0;
      end else begin
         sync_r      <= {sync_r[0], key_raw};
         press_pulse <= settle_s && !sync_r[1];
         if (sync_r[1] == key_level) begin
            cnt_r <= '0;
         end else if (settle_s) begin
            cnt_r     <= '0;
            key_level <= sync_r[1];
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/av_control_hub.sv
// Frame-synchronous control hub: key enables, clamped BPM and beat hold, all committed at frame start.
// Define AV_HUB_KEY_MOMENTARY_EN for enable-while-held keys instead of toggle-on-press.
module av_control_hub
   import av_hub_pkg::*;
#(
   parameter int NUM_FILTERS  = 4,
   parameter int BPM_W        = 8,
   parameter int MIN_BPM      = 40,
   parameter int MAX_BPM      = 200,
   parameter int DEBOUNCE_CYC = 250000,
   parameter int HOLD_FRAMES  = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_FILTERS-1:0] key_n,
   input  logic [BPM_W-1:0]       bpm_in,
   input  logic                   bpm_valid,
   input  logic                   beat_in,
   input  logic                   frame_start,
   output logic [NUM_FILTERS-1:0] filter_enable,
   output logic [BPM_W-1:0]       bpm_frame,
   output logic                   beat_active,
   output logic [FRAME_CNT_W-1:0] frame_count
);

   localparam int HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

   logic [NUM_FILTERS-1:0] pend_next_s;
   logic [BPM_W-1:0]       pend_bpm_r;
   logic [BPM_W-1:0]       bpm_clamped_s;
   logic [1:0]             beat_sync_r;
   logic                   beat_prev_r;
   logic                   beat_rise_s;
   logic [HOLD_W-1:0]      hold_cnt_r;
   logic [HOLD_W-1:0]      hold_next_s;

`ifdef AV_HUB_KEY_MOMENTARY_EN
   logic [NUM_FILTERS-1:0] key_level_s;

   for (genvar i = 0; i < NUM_FILTERS; i++) begin : g_key
      key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
         .clk         (clk),
         .reset       (reset),
         .key_raw     (key_n[i]),
         .key_level   (key_level_s[i]),
         .press_pulse ()
      );
   end

   assign pend_next_s = ~key_level_s;
`else
   logic [NUM_FILTERS-1:0] press_s;
   logic [NUM_FILTERS-1:0] pend_en_r;

   for (genvar i = 0; i < NUM_FILTERS; i++) begin : g_key
      key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
         .clk         (clk),
         .reset       (reset),
         .key_raw     (key_n[i]),
         .key_level   (),
         .press_pulse (press_s[i])
      );
   end

   // A press landing on the frame_start cycle is already folded into what gets committed.
   assign pend_next_s = pend_en_r ^ press_s;

   // Pending toggle state per filter stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_en_r <= '0;
      end else begin
         pend_en_r <= pend_next_s;
      end
   end
`endif

   assign bpm_clamped_s = BPM_W'(clamp_bpm(bpm_t'(bpm_in), bpm_t'(MIN_BPM), bpm_t'(MAX_BPM)));

   // Pending BPM captured on every valid estimate
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_bpm_r <= '0;
      end else if (bpm_valid) begin
         pend_bpm_r <= bpm_clamped_s;
      end
   end

   // Frame-start commit of enables, BPM and the frame counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filter_enable <= '0;
         bpm_frame     <= '0;
         frame_count   <= '0;
      end else if (frame_start) begin
         filter_enable <= pend_next_s;
         bpm_frame     <= bpm_valid ? bpm_clamped_s : pend_bpm_r;
         frame_count   <= frame_count + FRAME_CNT_W'(1);
      end
   end

   assign beat_rise_s = beat_sync_r[1] && !beat_prev_r;

   // Reload beats decrement when a beat edge and frame_start coincide.
   always_comb begin
      hold_next_s = hold_cnt_r;
      if (beat_rise_s) begin
         hold_next_s = HOLD_W'(HOLD_FRAMES);
      end else if (frame_start && (hold_cnt_r != '0)) begin
         hold_next_s = hold_cnt_r - HOLD_W'(1);
      end else begin
         hold_next_s = hold_cnt_r;
      end
   end

   // Beat synchroniser, edge history and hold counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beat_sync_r <= 2'b00;
         beat_prev_r <= 1'b0;
         hold_cnt_r  <= '0;
         beat_active <= 1'b0;
      end else begin
         beat_sync_r <= {beat_sync_r[0], beat_in};
         beat_prev_r <= beat_sync_r[1];
         hold_cnt_r  <= hold_next_s;
         beat_active <= (hold_next_s != '0);
      end
   end

endmodule

// File: tb/tb_av_control_hub.sv
// Self-checking bench for av_control_hub: behavioural model plus directed and random stimulus.
module tb_av_control_hub;

   localparam int DEB  = 4;
   localparam int HOLD = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  key_n = 4'hF;
   logic [7:0]  bpm_in = 8'd0;
   logic        bpm_valid = 1'b0;
   logic        beat_in = 1'b0;
   logic        frame_start = 1'b0;
   logic [3:0]  filter_enable;
   logic [7:0]  bpm_frame;
   logic        beat_active;
   logic [15:0] frame_count;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_on = 1'b0;

   // Expected pending enables, maintained by the stimulus at press granularity.
   logic [3:0]  exp_pend = 4'h0;

   logic [3:0]  m_fe;
   logic [7:0]  m_pend_bpm, m_bpm;
   logic [15:0] m_count;
   int          m_hold;
   logic        d1, d2, d3;

   always #5 clk = ~clk;

   av_control_hub #(
      .NUM_FILTERS(4), .BPM_W(8), .MIN_BPM(40), .MAX_BPM(200),
      .DEBOUNCE_CYC(DEB), .HOLD_FRAMES(HOLD)
   ) dut (
      .clk(clk), .reset(reset), .key_n(key_n), .bpm_in(bpm_in), .bpm_valid(bpm_valid),
      .beat_in(beat_in), .frame_start(frame_start), .filter_enable(filter_enable),
      .bpm_frame(bpm_frame), .beat_active(beat_active), .frame_count(frame_count)
   );

   function automatic logic [7:0] ref_bpm(input logic [7:0] v);
      int x;
      x = int'(v);
      if (x == 0) return 8'd0;
      if (x < 40) return 8'd40;
      if (x > 200) return 8'd200;
      return v;
   endfunction

   // Reference model: beat level is seen two input-cycles late, rise vs the cycle before that.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_fe <= 4'h0; m_pend_bpm <= 8'd0; m_bpm <= 8'd0; m_count <= 16'd0;
         m_hold <= 0; d1 <= 1'b0; d2 <= 1'b0; d3 <= 1'b0;
      end else begin
         if (bpm_valid) m_pend_bpm <= ref_bpm(bpm_in);
         if (frame_start) begin
            m_fe    <= exp_pend;
            m_bpm   <= bpm_valid ? ref_bpm(bpm_in) : m_pend_bpm;
            m_count <= m_count + 16'd1;
         end
         d1 <= beat_in; d2 <= d1; d3 <= d2;
         if (d2 && !d3) m_hold <= HOLD;
         else if (frame_start && m_hold > 0) m_hold <= m_hold - 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_on) begin
            check("filter_enable", 32'(filter_enable), 32'(m_fe));
            check("bpm_frame", 32'(bpm_frame), 32'(m_bpm));
            check("beat_active", 32'(beat_active), 32'(m_hold != 0));
            check("frame_count", 32'(frame_count), 32'(m_count));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press_key(input int i, input int len);
      key_n[i] = 1'b0;
      tick(len);
      key_n[i] = 1'b1;
      tick(12);
      exp_pend[i] = ~exp_pend[i];
   endtask

   task automatic bounce_key(input int i, input bit rnd);
      for (int k = 0; k < 10; k++) begin
         key_n[i] = (k % 2 == 1);
         tick(rnd ? $urandom_range(1, 2) : 2);
      end
      key_n[i] = 1'b1;
      tick(12);
   endtask

   task automatic send_frame();
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
   endtask

   task automatic send_bpm(input logic [7:0] v);
      bpm_in = v;
      bpm_valid = 1'b1;
      tick(1);
      bpm_valid = 1'b0;
   endtask

   task automatic beat_pulse();
      beat_in = 1'b1;
      tick(1);
      beat_in = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_pend = 4'h0;
      key_n = 4'hF;
      beat_in = 1'b0;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] bv;
      logic [7:0] bpm_tab [4];
      logic [7:0] bpm_exp [4];
      int k;
      bpm_tab[0] = 8'd25; bpm_tab[1] = 8'd230; bpm_tab[2] = 8'd0;  bpm_tab[3] = 8'd120;
      bpm_exp[0] = 8'd40; bpm_exp[1] = 8'd200; bpm_exp[2] = 8'd0;  bpm_exp[3] = 8'd120;

      @(posedge clk);
      cmp_on = 1'b1;
      #1;
      tick(2);
      reset = 1'b0;
      @(negedge clk);
      check("reset_fe", 32'(filter_enable), 32'h0);
      check("reset_bpm", 32'(bpm_frame), 32'h0);
      check("reset_beat", 32'(beat_active), 32'h0);
      check("reset_count", 32'(frame_count), 32'h0);
      tick(1);

      press_key(1, 6); send_frame();
      @(negedge clk); check("press_on", 32'(filter_enable), 32'h2);
      press_key(1, 6); send_frame();
      @(negedge clk); check("press_off", 32'(filter_enable), 32'h0);

      bounce_key(0, 1'b0); send_frame();
      @(negedge clk); check("bounce", 32'(filter_enable), 32'h0);

      for (int i = 0; i < 4; i++) begin
         send_bpm(bpm_tab[i]); send_frame();
         @(negedge clk); check("bpm_clamp", 32'(bpm_frame), 32'(bpm_exp[i]));
      end
      send_frame(); send_frame();
      @(negedge clk); check("bpm_hold", 32'(bpm_frame), 32'd120);

      bpm_in = 8'd90; bpm_valid = 1'b1; frame_start = 1'b1;
      tick(1);
      bpm_valid = 1'b0; frame_start = 1'b0;
      @(negedge clk); check("bpm_bypass", 32'(bpm_frame), 32'd90);

      beat_pulse();
      k = 0;
      while (!beat_active && k < 8) begin tick(1); k++; end
      check("beat_rise", 32'(beat_active), 32'h1);
      send_frame(); send_frame();
      @(negedge clk); check("beat_after2", 32'(beat_active), 32'h1);
      send_frame();
      @(negedge clk); check("beat_after3", 32'(beat_active), 32'h0);

      beat_pulse();
      tick(4);
      send_frame();
      beat_in = 1'b1; tick(1); beat_in = 1'b0; tick(1);
      send_frame();
      send_frame(); send_frame();
      @(negedge clk); check("beat_reload2", 32'(beat_active), 32'h1);
      send_frame();
      @(negedge clk); check("beat_reload3", 32'(beat_active), 32'h0);

      for (int i = 0; i < 4; i++) press_key(i, 7);
      send_bpm(8'd120); send_frame();
      @(negedge clk);
      check("all_on", 32'(filter_enable), 32'hF);
      check("bpm_120", 32'(bpm_frame), 32'd120);
      tick(3);
      @(posedge clk); #3;
      reset = 1'b1;
      exp_pend = 4'h0;
      #1;
      check("async_fe", 32'(filter_enable), 32'h0);
      check("async_bpm", 32'(bpm_frame), 32'h0);
      check("async_count", 32'(frame_count), 32'h0);
      tick(2);
      reset = 1'b0;
      tick(2);

      for (int it = 0; it < 400; it++) begin
         case ($urandom_range(0, 6))
            0: press_key(int'($urandom_range(0, 3)), int'($urandom_range(6, 10)));
            1: bounce_key(int'($urandom_range(0, 3)), 1'b1);
            2: begin
               case ($urandom_range(0, 5))
                  0: bv = 8'd0;
                  1: bv = 8'($urandom_range(1, 39));
                  2: bv = 8'd40;
                  3: bv = 8'd200;
                  4: bv = 8'($urandom_range(201, 255));
                  default: bv = 8'($urandom_range(41, 199));
               endcase
               send_bpm(bv);
            end
            3: send_frame();
            4: begin beat_in = ~beat_in; tick(int'($urandom_range(1, 3))); end
            5: begin
               bpm_in = 8'($urandom); bpm_valid = 1'b1; frame_start = 1'b1;
               tick(1);
               bpm_valid = 1'b0; frame_start = 1'b0;
            end
            default: begin
               beat_in = ~beat_in; frame_start = 1'b1;
               tick(1);
               frame_start = 1'b0;
            end
         endcase
      end

      beat_in = 1'b0;
      tick(4);
      do_reset();
      frame_start = 1'b1;
      tick(65535);
      @(negedge clk); check("count_ffff", 32'(frame_count), 32'hFFFF);
      tick(1);
      frame_start = 1'b0;
      @(negedge clk); check("count_wrap", 32'(frame_count), 32'h0);
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
